escaner_teclado: RTL and testbench
==================================

Name: escaner_teclado

Overview:
Parametrised matrix-keypad scanner that supersedes the combinational row/column-to-code comparator. It drives the keypad columns one-hot, samples the rows, debounces each press and release, and encodes the key. It also holds the code in a one-entry output register with a valid/read handshake. It sits between the keypad pins and the UNPARKING control logic, which consumes key codes.

Parameters:
FILAS, 4, number of keypad rows (2..8)
COLUMNAS, 4, number of keypad columns (2..8)
T_BARRIDO, 1000, clock cycles each column stays driven during scan (>=3)
N_REBOTE, 10000, consecutive stable cycles required for press and for release (>=2)
MAPA_HEX, 1, 1 = legacy 4x4 hex layout (valid only when FILAS=COLUMNAS=4); 0 = linear code fila*COLUMNAS+col
ANCHO_NUM, 6, width of num; must hold FILAS*COLUMNAS-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
filas  input  FILAS  row sense lines, active-high, asynchronous to clk
columnas  output  COLUMNAS  column drive, one-hot active-high
num  output  ANCHO_NUM  code of last accepted key
num_valido  output  1  num holds an unread key
leido  input  1  consumer read strobe, one cycle
sobrecarga  output  1  sticky: a key was accepted while num_valido=1
tecla_activa  output  1  high from press acceptance until release accepted

Behaviour:
- Index convention: column index c drives bit COLUMNAS-1-c; row index f is bit FILAS-1-f (MSB = index 0).
- filas passes through a 2-flop synchroniser. All decisions use the synchronised value (2-cycle input latency).
- Reset (async assert, sync release): columnas = one-hot bit COLUMNAS-1, num=0, num_valido=0, sobrecarga=0, tecla_activa=0, state BARRIDO, counters 0.
- FSM states:
  - BARRIDO: hold current column for T_BARRIDO cycles, then sample synced filas on the last cycle of the slot.
    - Sample zero -> advance to next column, wrapping from index COLUMNAS-1 to 0.
    - Sample exactly one-hot -> capture pattern, go to REBOTE with the column still held.
    - Sample non-zero but not one-hot (multi-key) -> ignore and advance column.
  - REBOTE: count cycles while synced filas equals the captured pattern.
    - Any mismatch -> back to BARRIDO at the next column, no output.
    - Count reaches N_REBOTE -> accept key, go to SOLTAR.
  - SOLTAR: column held, tecla_activa=1. Count consecutive cycles with synced filas==0; any non-zero resets the count. Count reaches N_REBOTE -> tecla_activa=0, go to BARRIDO at the next column.
- Acceptance, in the cycle after the N_REBOTE-th stable cycle:
  - num loads the code and num_valido rises.
  - If num_valido was already 1 and leido is not asserted that cycle, num is overwritten and sobrecarga sets.
- Handshake: leido while num_valido=1 clears num_valido next cycle. leido with num_valido=0 has no effect. leido coincident with acceptance: the new key wins, num_valido stays 1, no sobrecarga. leido clears sobrecarga.
- MAPA_HEX=1 codes, rows 0..3, columns 0..3:
  - row 0: 1,2,3,A
  - row 1: 4,5,6,B
  - row 2: 7,8,9,C
  - row 3: E,0,F,D
- MAPA_HEX=0: code = f*COLUMNAS+c.
- Exactly one column is driven at all times, including while held in REBOTE and SOLTAR.
- Counters are sized for the larger of T_BARRIDO and N_REBOTE and must never wrap.
- Reset mid-press: all state returns to reset values and no key is emitted.

Test Plan:
- Reset: rst_n=0 mid-REBOTE -> columnas=4'b1000, num=0, num_valido=0, tecla_activa=0 immediately, asynchronously.
- Clean press (4x4, MAPA_HEX=1, T_BARRIDO=4, N_REBOTE=8): filas=4'b0010 held while columnas=4'b0001 -> num=4'hC, num_valido=1 within 2+4+8+1 cycles of the column slot start; columnas stays 4'b0001 until 8 release cycles after filas=0.
- Bounce: filas toggles 4'b1000/0 every 3 cycles on column 0 -> no num_valido. Then a stable hold -> num=4'h1.
- Multi-key: filas=4'b1100 on column 1 -> scan continues, no output. Key at row 3, column 1 -> num=0.
- Overflow: accept '5', no leido, accept '9' -> num=9, sobrecarga=1. leido -> num_valido=0, sobrecarga=0.
- Linear mode (FILAS=3, COLUMNAS=5, MAPA_HEX=0): key at row 2, column 4 -> num=14. Column wrap checked 4->0.

Source files
------------

// File: rtl/escaner_teclado.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sensing,
// press/release debounce and a one-entry key-code register with read handshake.
module escaner_teclado #(
    parameter int FILAS     = 4,
    parameter int COLUMNAS  = 4,
    parameter int T_BARRIDO = 1000,
    parameter int N_REBOTE  = 10000,
    parameter int MAPA_HEX  = 1,
    parameter int ANCHO_NUM = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FILAS-1:0]     filas,
    output logic [COLUMNAS-1:0]  columnas,
    output logic [ANCHO_NUM-1:0] num,
    output logic                 num_valido,
    input  logic                 leido,
    output logic                 sobrecarga,
    output logic                 tecla_activa
);
    localparam int MAX_CUENTA = (T_BARRIDO > N_REBOTE) ? T_BARRIDO : N_REBOTE;
    localparam int CW = $clog2(MAX_CUENTA + 1);
    localparam int CI = $clog2(COLUMNAS);
    localparam int FI = (FILAS > 1) ? $clog2(FILAS) : 1;

    typedef enum logic [1:0] {BARRIDO, REBOTE, SOLTAR} estado_t;

    estado_t              estado_reg, estado_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [CI-1:0]        col_reg, col_next, col_sig;
    logic [FILAS-1:0]     patron_reg, patron_next;
    logic [FILAS-1:0]     filas_s1_reg, filas_s2_reg;
    logic [ANCHO_NUM-1:0] num_reg;
    logic                 num_valido_reg, sobrecarga_reg;
    logic                 acepta;
    logic                 es_onehot;
    logic [FI-1:0]        fila_idx;
    logic [3:0]           hex_sel, hex_cod;
    logic [ANCHO_NUM-1:0] codigo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filas_s1_reg <= '0;
            filas_s2_reg <= '0;
        end else begin
            filas_s1_reg <= filas;
            filas_s2_reg <= filas_s1_reg;
        end
    end

    assign es_onehot = (filas_s2_reg != '0) &&
                       ((filas_s2_reg & (filas_s2_reg - FILAS'(1))) == '0);
    assign col_sig   = (col_reg == CI'(COLUMNAS - 1)) ? '0 : col_reg + CI'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg <= BARRIDO;
            cnt_reg    <= '0;
            col_reg    <= '0;
            patron_reg <= '0;
        end else begin
            estado_reg <= estado_next;
            cnt_reg    <= cnt_next;
            col_reg    <= col_next;
            patron_reg <= patron_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        cnt_next    = cnt_reg;
        col_next    = col_reg;
        patron_next = patron_reg;
        acepta      = 1'b0;
        unique case (estado_reg)
            BARRIDO: begin
                // Rows are judged only on the last cycle of the slot, once the
                // synchroniser has flushed the previous column's response.
                if (cnt_reg == CW'(T_BARRIDO - 1)) begin
                    cnt_next = '0;
                    if (es_onehot) begin
                        patron_next = filas_s2_reg;
                        estado_next = REBOTE;
                    end else begin
                        col_next = col_sig;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            REBOTE: begin
                if (filas_s2_reg != patron_reg) begin
                    estado_next = BARRIDO;
                    cnt_next    = '0;
                    col_next    = col_sig;
                end else if (cnt_reg == CW'(N_REBOTE - 1)) begin
                    acepta      = 1'b1;
                    estado_next = SOLTAR;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            SOLTAR: begin
                if (filas_s2_reg != '0) begin
                    cnt_next = '0;
                end else if (cnt_reg == CW'(N_REBOTE - 1)) begin
                    estado_next = BARRIDO;
                    cnt_next    = '0;
                    col_next    = col_sig;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                estado_next = BARRIDO;
                cnt_next    = '0;
            end
        endcase
    end

    // Row index 0 is the MSB of filas.
    always_comb begin
        fila_idx = '0;
        for (int i = 0; i < FILAS; i++) begin
            if (patron_reg[FILAS-1-i]) fila_idx = FI'(i);
        end
    end

    always_comb begin
        hex_sel = {2'(fila_idx), 2'(col_reg)};
        hex_cod = 4'h0;
        case (hex_sel)
            4'd0:  hex_cod = 4'h1;
            4'd1:  hex_cod = 4'h2;
            4'd2:  hex_cod = 4'h3;
            4'd3:  hex_cod = 4'hA;
            4'd4:  hex_cod = 4'h4;
            4'd5:  hex_cod = 4'h5;
            4'd6:  hex_cod = 4'h6;
            4'd7:  hex_cod = 4'hB;
            4'd8:  hex_cod = 4'h7;
            4'd9:  hex_cod = 4'h8;
            4'd10: hex_cod = 4'h9;
            4'd11: hex_cod = 4'hC;
            4'd12: hex_cod = 4'hE;
            4'd13: hex_cod = 4'h0;
            4'd14: hex_cod = 4'hF;
            default: hex_cod = 4'hD;
        endcase
        if (MAPA_HEX != 0) begin
            codigo = ANCHO_NUM'(hex_cod);
        end else begin
            codigo = ANCHO_NUM'(fila_idx) * ANCHO_NUM'(COLUMNAS) + ANCHO_NUM'(col_reg);
        end
    end

    // A read coinciding with acceptance lets the new key through without overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_reg        <= '0;
            num_valido_reg <= 1'b0;
            sobrecarga_reg <= 1'b0;
        end else if (acepta) begin
            num_reg        <= codigo;
            num_valido_reg <= 1'b1;
            if (num_valido_reg && !leido) begin
                sobrecarga_reg <= 1'b1;
            end else if (leido) begin
                sobrecarga_reg <= 1'b0;
            end
        end else if (leido) begin
            num_valido_reg <= 1'b0;
            sobrecarga_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < COLUMNAS; gi++) begin : g_columna
            assign columnas[COLUMNAS-1-gi] = (col_reg == CI'(gi));
        end
    endgenerate

    assign num          = num_reg;
    assign num_valido   = num_valido_reg;
    assign sobrecarga   = sobrecarga_reg;
    assign tecla_activa = (estado_reg == SOLTAR);

endmodule

// File: tb/tb_escaner_teclado.sv
// Bench for escaner_teclado: a keypad model drives the rows from the driven
// column; expected key codes go to a queue checked on each key acceptance.
module tb_escaner_teclado;
    localparam int FL = 4, CL = 4, TB = 4, NR = 8, AN = 6;
    localparam int FL2 = 3, CL2 = 5;
    localparam int HOLD = 50, REL = 25;

    typedef struct {
        int code;
        bit sob;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [FL-1:0]  filas;
    logic [CL-1:0]  columnas;
    logic [AN-1:0]  num;
    logic           num_valido, sobrecarga, tecla_activa;
    logic           leido = 1'b0;

    logic [FL2-1:0] filas_l;
    logic [CL2-1:0] columnas_l;
    logic [AN-1:0]  num_l;
    logic           num_valido_l, sobrecarga_l, tecla_activa_l;
    logic           leido_l = 1'b0;

    logic key_on = 1'b0, key2_on = 1'b0;
    int   key_r = 0, key2_r = 0, key_c = 0;
    logic lk_on = 1'b0;
    int   lk_r = 0, lk_c = 0;

    int   hex_tab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    exp_t q[$];
    int   ql[$];
    int   tests = 0, fails = 0;
    bit   mdl_unread = 0;
    int   mdl_last = 0;

    escaner_teclado #(.FILAS(FL), .COLUMNAS(CL), .T_BARRIDO(TB), .N_REBOTE(NR),
                      .MAPA_HEX(1), .ANCHO_NUM(AN)) dut (
        .clk(clk), .rst_n(rst_n), .filas(filas), .columnas(columnas), .num(num),
        .num_valido(num_valido), .leido(leido), .sobrecarga(sobrecarga),
        .tecla_activa(tecla_activa));

    escaner_teclado #(.FILAS(FL2), .COLUMNAS(CL2), .T_BARRIDO(TB), .N_REBOTE(NR),
                      .MAPA_HEX(0), .ANCHO_NUM(AN)) dut_lin (
        .clk(clk), .rst_n(rst_n), .filas(filas_l), .columnas(columnas_l), .num(num_l),
        .num_valido(num_valido_l), .leido(leido_l), .sobrecarga(sobrecarga_l),
        .tecla_activa(tecla_activa_l));

    // Physical keypad: a closed key connects its column line to its row line.
    always_comb begin
        filas = '0;
        if (key_on && columnas[CL-1-key_c])  filas[FL-1-key_r]  = 1'b1;
        if (key2_on && columnas[CL-1-key_c]) filas[FL-1-key2_r] = 1'b1;
    end

    always_comb begin
        filas_l = '0;
        if (lk_on && columnas_l[CL2-1-lk_c]) filas_l[FL2-1-lk_r] = 1'b1;
    end

    task automatic check(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end else begin
            $display("[TB] ok %s = %0d", nm, act);
        end
    endtask

    logic ta_prev = 1'b0, tal_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && tecla_activa && !ta_prev) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_key: got num=%0d, required no key", num);
            end else begin
                e = q.pop_front();
                check("key_num", int'(num), e.code);
                check("key_valid", int'(num_valido), 1);
                check("key_sobrecarga", int'(sobrecarga), int'(e.sob));
            end
        end
        ta_prev = tecla_activa;
    end

    always @(negedge clk) begin
        int el;
        if (rst_n && tecla_activa_l && !tal_prev) begin
            if (ql.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_lin_key: got num=%0d, required no key", num_l);
            end else begin
                el = ql.pop_front();
                check("lin_num", int'(num_l), el);
                check("lin_valid", int'(num_valido_l), 1);
            end
        end
        tal_prev = tecla_activa_l;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input logic [CL-1:0] v);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (columnas == v) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_col: got columnas=%b, required %b within 200 cycles", columnas, v);
        end
    endtask

    task automatic press_clean(input int r, input int c, input bit rebote);
        key_r = r;
        key_c = c;
        key2_on = 0;
        if (rebote) begin
            key_on = 0;
            repeat (10) begin
                key_on = ~key_on;
                cyc(3);
            end
            key_on = 0;
            cyc(3);
            check("bounce_no_valid", int'(num_valido), int'(mdl_unread));
        end
        q.push_back(exp_t'{hex_tab[r][c], mdl_unread});
        mdl_last   = hex_tab[r][c];
        mdl_unread = 1;
        key_on = 1;
        cyc(HOLD);
        key_on = 0;
        cyc(REL);
    endtask

    task automatic press_multi(input int c, input int r1, input int r2);
        key_c = c;
        key_r = r1;
        key2_r = r2;
        key_on = 1;
        key2_on = 1;
        cyc(HOLD);
        key_on = 0;
        key2_on = 0;
        cyc(REL);
        check("multi_valid", int'(num_valido), int'(mdl_unread));
    endtask

    task automatic read_key();
        leido = 1;
        cyc(1);
        leido = 0;
        check("read_valid", int'(num_valido), 0);
        check("read_sobrecarga", int'(sobrecarga), 0);
        check("read_num_kept", int'(num), mdl_last);
        mdl_unread = 0;
    endtask

    task automatic press_lin(input int r, input int c);
        ql.push_back(r * CL2 + c);
        lk_r = r;
        lk_c = c;
        lk_on = 1;
        cyc(HOLD);
        lk_on = 0;
        cyc(REL);
        leido_l = 1;
        cyc(1);
        leido_l = 0;
        check("lin_read_valid", int'(num_valido_l), 0);
    endtask

    initial begin
        int lat, n, wraps;
        logic [CL2-1:0] prev, req;

        #1;
        check("rst_columnas", int'(columnas), 4'b1000);
        check("rst_num", int'(num), 0);
        check("rst_valid", int'(num_valido), 0);
        check("rst_activa", int'(tecla_activa), 0);
        cyc(3);
        rst_n = 1;
        cyc(2);

        // Clean press at row 2, column 3 with latency and release-hold bounds.
        wait_col(4'b1000);
        key_r = 2; key_c = 3; key_on = 1;
        q.push_back(exp_t'{12, mdl_unread});
        mdl_last = 12; mdl_unread = 1;
        wait_col(4'b0001);
        lat = 0;
        while (!tecla_activa && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat > 15) begin
            fails++;
            $display("FAIL accept_latency: got %0d cycles, required <= 15", lat);
        end
        @(posedge clk);
        #1 key_on = 0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (columnas == 4'b0001) n++;
            else break;
        end
        tests++;
        if (n < 8 || n > 12) begin
            fails++;
            $display("FAIL release_hold: got %0d cycles, required 8..12", n);
        end
        cyc(5);
        read_key();

        press_clean(0, 0, 1);
        read_key();
        press_multi(1, 0, 1);
        press_clean(3, 1, 0);
        read_key();

        press_clean(1, 1, 0);
        press_clean(2, 2, 0);
        check("overflow_flag", int'(sobrecarga), 1);
        read_key();

        for (int it = 0; it < 12; it++) begin
            int kind, r, c;
            kind = int'($urandom_range(0, 2));
            r    = int'($urandom_range(0, 3));
            c    = int'($urandom_range(0, 3));
            case (kind)
                0: press_clean(r, c, 0);
                1: press_clean(r, c, 1);
                default: press_multi(c, r, (r + 1 + int'($urandom_range(0, 2))) % 4);
            endcase
            if ($urandom_range(0, 1) == 1) read_key();
        end

        // Reset while a key is being debounced.
        press_clean(0, 3, 0);
        wait_col(4'b0100);
        wait_col(4'b1000);
        key_r = 0; key_c = 0; key_on = 1;
        repeat (6) @(negedge clk);
        rst_n = 0;
        #1;
        check("midrst_columnas", int'(columnas), 4'b1000);
        check("midrst_num", int'(num), 0);
        check("midrst_valid", int'(num_valido), 0);
        check("midrst_activa", int'(tecla_activa), 0);
        check("midrst_sobrecarga", int'(sobrecarga), 0);
        key_on = 0;
        cyc(3);
        rst_n = 1;
        mdl_unread = 0;
        mdl_last = 0;
        cyc(40);
        check("postrst_valid", int'(num_valido), 0);
        check("postrst_num", int'(num), 0);

        // Linear-code instance: column order and wrap, then keys.
        prev = columnas_l;
        wraps = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (columnas_l != prev) begin
                req = (prev == 5'b00001) ? 5'b10000 : (prev >> 1);
                check("lin_col_step", int'(columnas_l), int'(req));
                if (prev == 5'b00001) wraps++;
                prev = columnas_l;
            end
        end
        check("lin_wrap_seen", int'(wraps > 0), 1);
        cyc(1);
        press_lin(2, 4);
        for (int it = 0; it < 4; it++) begin
            press_lin(int'($urandom_range(0, FL2 - 1)), int'($urandom_range(0, CL2 - 1)));
        end

        check("queue_drained", q.size(), 0);
        check("lin_queue_drained", ql.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
